// File: rtl/fifo_bram_fwft.sv
// BRAM-backed synchronous FIFO, first-word-fall-through head on o_rdata.
// Latency: write at edge k appears at head after edge k+2; pops sustain one word per cycle.
// Backpressure: writes dropped while full (o_overflow), reads ignored while empty (o_underflow).
module fifo_bram_fwft #(
    parameter int DEPTH        = 128,
    parameter int WIDTH        = 8,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_write,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_read,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    wptr_q, bptr_q, count_q;
    logic [WIDTH-1:0] rd_dat_q, head_q, nxt_q;
    logic             rd_vld_q, head_vld_q, nxt_vld_q;
    logic             full_q, afull_q, aempty_q, ovf_q, unf_q;

    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_d, nxt_d;
    logic             head_vld_d, nxt_vld_d;
    logic             wr_acc, rd_acc, bram_rd;
    logic [1:0]       occ;

    assign wr_acc  = i_write && !full_q;
    assign rd_acc  = i_read && head_vld_q;
    assign count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

    // Words in the output stage plus the one in flight from BRAM never exceed two.
    assign occ     = {1'b0, head_vld_q} + {1'b0, nxt_vld_q} + {1'b0, rd_vld_q};
    assign bram_rd = (bptr_q != wptr_q) && ((occ < 2'd2) || (occ == 2'd2 && rd_acc));

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        nxt_d      = nxt_q;
        nxt_vld_d  = nxt_vld_q;
        if (rd_acc) begin
            head_d     = nxt_q;
            head_vld_d = nxt_vld_q;
            nxt_vld_d  = 1'b0;
        end
        if (rd_vld_q) begin
            if (!head_vld_d) begin
                head_d     = rd_dat_q;
                head_vld_d = 1'b1;
            end else begin
                nxt_d     = rd_dat_q;
                nxt_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_acc) begin
            mem[wptr_q[AW-1:0]] <= i_wdata;
        end
        if (bram_rd) begin
            rd_dat_q <= mem[bptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wptr_q     <= '0;
            bptr_q     <= '0;
            count_q    <= '0;
            rd_vld_q   <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            nxt_q      <= '0;
            nxt_vld_q  <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (bram_rd) begin
                bptr_q <= bptr_q + 1'b1;
            end
            count_q    <= count_d;
            rd_vld_q   <= bram_rd;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            nxt_q      <= nxt_d;
            nxt_vld_q  <= nxt_vld_d;
            full_q     <= (count_d == DEPTH_C);
            afull_q    <= (count_d >= AF_C);
            aempty_q   <= (count_d <= AE_C);
            if (i_write && full_q) begin
                ovf_q <= 1'b1;
            end
            if (i_read && !head_vld_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign o_rdata        = head_q;
    assign o_empty        = !head_vld_q;
    assign o_full         = full_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;
endmodule

// File: tb/tb_fifo_bram_fwft.sv
// Bench for fifo_bram_fwft: queue-based reference with per-word write timestamps
// to model the two-cycle fall-through, driven by directed and random steps.
module tb_fifo_bram_fwft;
    localparam int D  = 128;
    localparam int AF = D - 4;
    localparam int AE = 4;

    logic       clk = 1'b0;
    logic       i_reset, i_write, i_read;
    logic [7:0] i_wdata, o_rdata;
    logic       o_empty, o_full, o_almost_full, o_almost_empty, o_overflow, o_underflow;
    logic [7:0] o_count;

    fifo_bram_fwft #(.DEPTH(D), .WIDTH(8), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_write(i_write), .i_wdata(i_wdata),
        .i_read(i_read), .o_rdata(o_rdata), .o_empty(o_empty), .o_full(o_full),
        .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
        .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] qd[$];
    int         qt[$];
    int         ec = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    // Head is visible once the front word has had two edges since its write.
    function automatic bit m_vis();
        return (qd.size() > 0) && (qt[0] + 2 <= ec);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ec);
        end
    endtask

    task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r);
        bit full_m, vis, wa, ra;
        @(negedge clk);
        i_reset = rst; i_write = w; i_wdata = d; i_read = r;
        @(posedge clk);
        if (rst) begin
            qd.delete(); qt.delete();
            m_ovf = 0; m_unf = 0;
        end else begin
            full_m = (qd.size() == D);
            vis    = m_vis();
            wa     = w && !full_m;
            ra     = r && vis;
            if (w && !wa) m_ovf = 1;
            if (r && !vis) m_unf = 1;
            if (ra) begin
                void'(qd.pop_front());
                void'(qt.pop_front());
            end
            if (wa) begin
                qd.push_back(d);
                qt.push_back(ec + 1);
            end
        end
        ec++;
        #1;
        chk("count", 32'(o_count), 32'(qd.size()));
        chk("empty", 32'(o_empty), 32'(!m_vis()));
        chk("full", 32'(o_full), 32'(qd.size() == D));
        chk("almost_full", 32'(o_almost_full), 32'(qd.size() >= AF));
        chk("almost_empty", 32'(o_almost_empty), 32'(qd.size() <= AE));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("underflow", 32'(o_underflow), 32'(m_unf));
        if (m_vis()) chk("rdata", 32'(o_rdata), 32'(qd[0]));
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * D && qd.size() > 0; i++) step(0, 0, 8'h00, 1);
        chk("drained", 32'(qd.size()), 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_write = 1'b0; i_wdata = '0; i_read = 1'b0;
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h33, 1);
        chk("reset_rdata", 32'(o_rdata), 32'h0);

        // Single word fall-through
        step(0, 1, 8'hA5, 0);
        chk("a5_count_k", 32'(o_count), 32'd1);
        chk("a5_empty_k", 32'(o_empty), 32'd1);
        step(0, 0, 8'h00, 0);
        chk("a5_empty_k1", 32'(o_empty), 32'd1);
        step(0, 0, 8'h00, 0);
        chk("a5_rdata_k2", 32'(o_rdata), 32'hA5);
        step(0, 0, 8'h00, 1);
        chk("a5_popped", 32'(o_empty), 32'd1);

        // Fill, overflow, drain in order
        for (int i = 0; i < D; i++) step(0, 1, 8'(i), 0);
        chk("fill_full", 32'(o_full), 32'd1);
        step(0, 1, 8'hEE, 0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        drain();

        // Underflow and write+read on empty
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("unf_set", 32'(o_underflow), 32'd1);
        step(0, 1, 8'h5C, 1);
        chk("wr_rd_empty_cnt", 32'(o_count), 32'd1);
        drain();

        // Full with simultaneous write+read
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < D; i++) step(0, 1, 8'($urandom), 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h77, 1);
        chk("full_wr_rd_cnt", 32'(o_count), 32'd127);
        chk("full_wr_rd_ovf", 32'(o_overflow), 32'd1);

        // Reset with 50 words queued
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 8'($urandom), 0);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'hEE, 0);
        step(1, 1, 8'h99, 1);
        chk("rst50_count", 32'(o_count), 32'd0);
        chk("rst50_empty", 32'(o_empty), 32'd1);
        for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom), 0);
        drain();

        // Continuous stream across many wraps
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 1000; i++) step(0, 1, 8'($urandom), i >= 3);
        chk("stream_count", 32'(o_count), 32'd3);
        drain();

        // Random traffic with varying rates
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4000; i++) begin
            int wp, rp;
            wp = (i / 500) % 2 == 0 ? 70 : 35;
            rp = 100 - wp;
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < wp),
                 8'($urandom), ($urandom_range(0, 99) < rp));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
